ctrl_result_drainer: RTL and testbench

//   Consumer side of the controller's state_count/end_signal sequencing interface.

---
 rtl/ctrl_result_drainer.sv | 119 +++++++++++
 tb/tb_ctrl_result_drainer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_result_drainer.sv
// Captures one run of pipelined multiplier results keyed by the controller's
// state_count, then streams them to the sink over a valid/ready handshake.
module ctrl_result_drainer #(
   parameter int DW        = 16,
   parameter int DEPTH     = 8,
   parameter int CAP_FIRST = 3,
   parameter int CAP_LAST  = 10
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [4:0]    state_count,
   input  logic          end_signal,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    dbg_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [4:0]    CF       = 5'(CAP_FIRST);
   localparam logic [4:0]    CL       = 5'(CAP_LAST);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

   // Handshake: a word transfers on every rising edge where out_valid && out_ready;
   // out_data/out_last are held unchanged while out_valid && !out_ready.

   logic [1:0]    state;
   logic [CW-1:0] cap_cnt;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          in_window;
   logic [DW-1:0] buf_mem [DEPTH];

   assign in_window = (state_count >= CF) && (state_count <= CL);
   assign wr_idx    = AW'(state_count - CF);

   assign out_valid = (state == DRAIN);
   assign out_last  = (state == DRAIN) && (rd_idx == IDX_LAST);
   assign busy      = (state == CAPTURE) || (state == DRAIN);
   assign done      = (state == DONE);
   assign dbg_state = state;

   // Buffer has no reset; its contents only matter after a full capture.
   always_ff @(posedge clk) begin
      if (state == CAPTURE && in_window) begin
         buf_mem[wr_idx] <= din;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cap_cnt  <= '0;
         rd_idx   <= '0;
         out_data <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !end_signal) begin
                  state   <= CAPTURE;
                  cap_cnt <= '0;
               end
            end
            CAPTURE: begin
               if (!start) begin
                  state <= IDLE;
               end else begin
                  // Saturate so a stalled controller cannot wrap the count to DEPTH.
                  if (in_window && cap_cnt != '1) begin
                     cap_cnt <= cap_cnt + CW'(1);
                  end
                  if (end_signal) begin
                     if (cap_cnt == CNT_FULL) begin
                        state    <= DRAIN;
                        rd_idx   <= '0;
                        out_data <= buf_mem[0];
                     end else begin
                        state <= DONE;
                        err   <= 1'b1;
                     end
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  rd_idx   <= rd_idx + AW'(1);
                  out_data <= buf_mem[rd_idx + AW'(1)];
                  if (rd_idx == IDX_LAST) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (!start) begin
                  state <= IDLE;
                  err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_result_drainer.sv
// Randomized bench for ctrl_result_drainer: a controller-like driver plus a
// queue-based model of which words the sink must receive, in which order.
module tb_ctrl_result_drainer;

   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic          clk;
   logic          rstn;
   logic          start;
   logic [4:0]    state_count;
   logic          end_signal;
   logic [DW-1:0] din;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   ctrl_result_drainer #(.DW(DW), .DEPTH(DEPTH), .CAP_FIRST(3), .CAP_LAST(10)) dut (
      .clk(clk), .rstn(rstn), .start(start), .state_count(state_count),
      .end_signal(end_signal), .din(din), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
      .err(err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_last"}, out_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // driver: leaves the bench at 1ns after a rising edge, DUT idle, rstn high
   task automatic do_reset();
      rstn = 1'b0; start = 1'b0; end_signal = 1'b0;
      state_count = '0; din = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("rst");
      check("rst_data", out_data, 0);
      check("rst_state", dbg_state, 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One controller run: counts 0..10 then 31 with end_signal (end_sc=31), or
   // raises end_signal early at end_sc; abort_sc drops start at that count.
   // rmode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0.
   task automatic run(input int end_sc, input int abort_sc, input int rmode,
                      input int rst_after, input bit nom, input int hold);
      logic [DW-1:0] mbuf [DEPTH];
      logic [DW-1:0] prev;
      logic [DW-1:0] exp_w;
      int cnt, i, sc, hs, cyc;
      bit short_err, stalled, ended, aborted;
      exp_q.delete();
      cnt = 0; i = 0; short_err = 0; ended = 0; aborted = 0;
      while (!ended && !aborted) begin
         sc = (end_sc == 31 && i == 11) ? 31 : i;
         state_count = 5'(sc);
         din = nom ? DW'(sc * 3) : DW'($urandom_range(0, 65535));
         start = (sc != abort_sc);
         end_signal = (sc == end_sc);
         check("busy_cap", busy, (i >= 1) ? 1 : 0);
         check("valid_cap", out_valid, 0);
         if (!start) aborted = 1;
         if (end_signal) begin
            ended = 1;
            short_err = (cnt != DEPTH);
         end
         if (i >= 1 && start && sc >= 3 && sc <= 10) begin
            mbuf[sc - 3] = din;
            cnt++;
         end
         @(posedge clk);
         #1;
         i++;
      end

      if (aborted) begin
         repeat (4) begin
            check_quiet("abort");
            state_count = 5'(i); i++;
            @(posedge clk);
            #1;
         end
         return;
      end

      state_count = 5'd31;
      if (!short_err) begin
         for (int k = 0; k < DEPTH; k++) exp_q.push_back(mbuf[k]);
         check("first_valid", out_valid, 1);
         hs = 0; cyc = 0; stalled = 0; prev = '0;
         while (exp_q.size() > 0 && cyc < 200) begin
            if (rst_after > 0 && hs == rst_after) begin
               rstn = 1'b0;
               #1;
               check_quiet("midrst");
               check("midrst_data", out_data, 0);
               return;
            end
            check("drain_valid", out_valid, 1);
            check("drain_busy", busy, 1);
            if (stalled) check("stall_stable", out_data, prev);
            check("last", out_last, (exp_q.size() == 1) ? 1 : 0);
            case (rmode)
               0:       out_ready = 1'b1;
               1:       out_ready = 1'($urandom_range(0, 1));
               default: out_ready = (cyc % 3 == 0);
            endcase
            if (out_valid && out_ready) begin
               exp_w = exp_q.pop_front();
               check("data", out_data, exp_w);
               hs++;
            end
            stalled = out_valid && !out_ready;
            prev = out_data;
            @(posedge clk);
            #1;
            cyc++;
         end
         check("drain_left", exp_q.size(), 0);
         check("handshakes", hs, DEPTH);
         if (rmode == 0) check("throughput", cyc, DEPTH);
         out_ready = 1'b0;
      end

      repeat (hold + 1) begin
         check("hold_done", done, 1);
         check("hold_err", err, short_err);
         check("hold_valid", out_valid, 0);
         check("hold_busy", busy, 0);
         state_count = 5'($urandom_range(0, 31));
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      check_quiet("release");
   endtask

   initial begin
      do_reset();
      run(31, -1, 0, 0, 1'b1, 2);     // nominal 9,12,..,30
      do_reset();
      run(31, -1, 2, 0, 1'b0, 2);     // backpressure 1,0,0
      do_reset();
      run(31, 5, 0, 0, 1'b0, 0);      // abort at state_count 5
      do_reset();
      run(6, -1, 0, 0, 1'b0, 3);      // short run -> err
      do_reset();
      run(31, -1, 0, 3, 1'b0, 0);     // reset mid-drain after 3 words
      do_reset();
      run(31, -1, 0, 0, 1'b1, 2);     // clean run after reset
      do_reset();
      run(31, -1, 1, 0, 1'b0, 20);    // done hold
      for (int r = 0; r < 6; r++) begin
         do_reset();
         run(31, -1, 1, 0, 1'b0, $urandom_range(0, 4));
      end
      // scoreboard report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
